// File: rtl/stack_mem_unit.sv
// Stack and memory responder for the JALA multicycle datapath: owns the main and
// return stack pointers, their sticky error flags, and a dual-port data memory.
module stack_mem_unit #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] MS_BASE  = 8'h80,
    parameter logic [ADDR_W-1:0] MS_LIMIT = 8'h40,
    parameter logic [ADDR_W-1:0] RS_BASE  = 8'hC0,
    parameter logic [ADDR_W-1:0] RS_LIMIT = 8'hA0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MSPWrite,
    input  logic              MSPop,
    input  logic              RSPWrite,
    input  logic              RSPop,
    input  logic              MemRead1,
    input  logic              MemRead2,
    input  logic              MemWrite1,
    input  logic              MemWrite2,
    input  logic [1:0]        MemDst1,
    input  logic [1:0]        MemDst2,
    input  logic [2:0]        MemData,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] res_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [DATA_W-1:0] valb_in,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [ADDR_W-1:0] msp,
    output logic [ADDR_W-1:0] rsp,
    output logic              ms_empty,
    output logic              rs_empty,
    output logic              ms_ovf,
    output logic              ms_unf,
    output logic              rs_ovf,
    output logic              rs_unf
);

    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;
    logic [ADDR_W-1:0] r_msp;
    logic [ADDR_W-1:0] r_rsp;
    logic              r_ms_ovf;
    logic              r_ms_unf;
    logic              r_rs_ovf;
    logic              r_rs_unf;

    logic [ADDR_W-1:0] w_msp_inc;
    logic [ADDR_W-1:0] w_addr1;
    logic [ADDR_W-1:0] w_addr2;
    logic [DATA_W-1:0] w_wdata2;
    logic [ADDR_W+1:0] w_ms_step;
    logic [ADDR_W+1:0] w_rs_step;

    function automatic logic [ADDR_W-1:0] f_addr(
        input logic [1:0]        sel,
        input logic [ADDR_W-1:0] sp_m,
        input logic [ADDR_W-1:0] sp_r,
        input logic [ADDR_W-1:0] dir,
        input logic [ADDR_W-1:0] sp_m_inc
    );
        case (sel)
            2'b00:   f_addr = sp_m;
            2'b01:   f_addr = sp_r;
            2'b10:   f_addr = dir;
            default: f_addr = sp_m_inc;
        endcase
    endfunction

    // Returns {underflow_hit, overflow_hit, next_ptr}; a blocked move leaves ptr as is.
    function automatic logic [ADDR_W+1:0] f_stack_step(
        input logic              pop,
        input logic [ADDR_W-1:0] ptr,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] limit
    );
        if (pop)
            f_stack_step = (ptr == base)  ? {2'b10, ptr} : {2'b00, ptr + ONE_A};
        else
            f_stack_step = (ptr == limit) ? {2'b01, ptr} : {2'b00, ptr - ONE_A};
    endfunction

    function automatic logic [DATA_W-1:0] f_wsel(
        input logic [2:0]        sel,
        input logic [DATA_W-1:0] pc,
        input logic [DATA_W-1:0] res,
        input logic [DATA_W-1:0] imm,
        input logic [DATA_W-1:0] valb
    );
        case (sel)
            3'b000:  f_wsel = pc;
            3'b001:  f_wsel = res;
            3'b011:  f_wsel = imm;
            3'b100:  f_wsel = valb;
            default: f_wsel = '0;
        endcase
    endfunction

    // Addresses resolve from the pointers as they stand before this edge's update.
    assign w_msp_inc = r_msp + ONE_A;
    assign w_addr1   = f_addr(MemDst1, r_msp, r_rsp, addr_in, w_msp_inc);
    assign w_addr2   = f_addr(MemDst2, r_msp, r_rsp, addr_in, w_msp_inc);
    assign w_wdata2  = f_wsel(MemData, pc_in, res_in, imm_in, valb_in);
    assign w_ms_step = f_stack_step(MSPop, r_msp, MS_BASE, MS_LIMIT);
    assign w_rs_step = f_stack_step(RSPop, r_rsp, RS_BASE, RS_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_msp    <= MS_BASE;
            r_rsp    <= RS_BASE;
            r_ms_ovf <= 1'b0;
            r_ms_unf <= 1'b0;
            r_rs_ovf <= 1'b0;
            r_rs_unf <= 1'b0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
        end else begin
            if (MSPWrite) begin
                r_msp <= w_ms_step[ADDR_W-1:0];
                if (w_ms_step[ADDR_W+1]) r_ms_unf <= 1'b1;
                if (w_ms_step[ADDR_W])   r_ms_ovf <= 1'b1;
            end
            if (RSPWrite) begin
                r_rsp <= w_rs_step[ADDR_W-1:0];
                if (w_rs_step[ADDR_W+1]) r_rs_unf <= 1'b1;
                if (w_rs_step[ADDR_W])   r_rs_ovf <= 1'b1;
            end
            if (MemRead1) r_rdata1 <= r_mem[w_addr1];
            if (MemRead2) r_rdata2 <= r_mem[w_addr2];
        end
    end

    // Memory is never cleared; port 2 is written last so it wins a same-address clash.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (MemWrite1) r_mem[w_addr1] <= wdata1;
            if (MemWrite2) r_mem[w_addr2] <= w_wdata2;
        end
    end

    assign rdata1   = r_rdata1;
    assign rdata2   = r_rdata2;
    assign msp      = r_msp;
    assign rsp      = r_rsp;
    assign ms_empty = (r_msp == MS_BASE);
    assign rs_empty = (r_rsp == RS_BASE);
    assign ms_ovf   = r_ms_ovf;
    assign ms_unf   = r_ms_unf;
    assign rs_ovf   = r_rs_ovf;
    assign rs_unf   = r_rs_unf;

endmodule
